// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates fetch and load/store requests onto one 64-bit
// memory. It handles the fixed read latency, load lane extraction/extension
// and read-modify-write for sub-doubleword stores.
module mem_access_ctrl #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_data_q, is_data_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [2:0]        lane_q, lane_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [63:0]       d_rdata_q, d_rdata_d;

  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_misal;
  logic [5:0]        sh;
  logic [63:0]       shifted, mask, load_ext, merged;

  // Select the request that would win arbitration and test its alignment.
  always_comb begin
    req_addr = d_req ? d_addr : if_addr;
    req_size = d_req ? d_size : 2'b10;
    case (req_size)
      2'b00:   req_misal = 1'b0;
      2'b01:   req_misal = req_addr[0];
      2'b10:   req_misal = |req_addr[1:0];
      default: req_misal = |req_addr[2:0];
    endcase
  end

  // Lane datapath: shift the read doubleword down to the addressed byte for
  // loads, and splice store bytes back into it for read-modify-write.
  always_comb begin
    sh      = {lane_q, 3'b000};
    shifted = mem_rdata >> sh;
    case (size_q)
      2'b00: begin
        mask     = 64'h0000_0000_0000_00FF;
        load_ext = uns_q ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        mask     = 64'h0000_0000_0000_FFFF;
        load_ext = uns_q ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        mask     = 64'h0000_0000_FFFF_FFFF;
        load_ext = uns_q ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        mask     = '1;
        load_ext = shifted;
      end
    endcase
    merged = (mem_rdata & ~(mask << sh)) | ((mem_wdata_q & mask) << sh);
  end

  // Next-state logic: arbitration and capture in IDLE, latency count in READ.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_data_d   = is_data_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    case (state_q)
      IDLE: begin
        // Grants are held off while reset is asserted so every output reads 0.
        if (!rst_n && (d_req || if_req)) begin
          d_gnt     = d_req;
          if_gnt    = !d_req;
          is_data_d = d_req;
          we_d      = d_req & d_we;
          size_d    = req_size;
          uns_d     = d_unsigned;
          lane_d    = req_addr[2:0];
          err_d     = req_misal;
          if (req_misal) begin
            state_d = RESP;
            if (d_req) d_rdata_d = '0;
            else       if_rdata_d = '0;
          end else begin
            mem_addr_d = {req_addr[ADDR_W-1:3], 3'b000};
            if (d_req && d_we) mem_wdata_d = d_wdata;
            if (d_req && d_we && req_size == 2'b11) begin
              state_d = WRITE;
            end else begin
              state_d = READ;
              cnt_d   = LAT_M1;
            end
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          if (we_q) begin
            mem_wdata_d = merged;
            state_d     = WRITE;
          end else begin
            state_d = RESP;
            if (is_data_q) d_rdata_d = load_ext;
            else           if_rdata_d = lane_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_data_q   <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      lane_q      <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_data_q   <= is_data_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Moore-style handshake outputs decoded from the state register.
  always_comb begin
    busy      = (state_q != IDLE);
    mem_we    = (state_q == WRITE);
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    if_valid  = (state_q == RESP) && !is_data_q;
    if_err    = (state_q == RESP) && !is_data_q && err_q;
    d_valid   = (state_q == WRITE) || ((state_q == RESP) && is_data_q);
    d_err     = (state_q == RESP) && is_data_q && err_q;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: table of transactions plus hand-written
// arbitration and reset sequences, checked through a scoreboard queue.
module tb_mem_access_ctrl;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned ADDR_W  = 64;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_valid, if_err;
  logic [31:0]       if_rdata;
  logic              d_req, d_we, d_unsigned;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic              d_gnt, d_valid, d_err;
  logic [63:0]       d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [63:0]       mem_wdata, mem_rdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_valid(d_valid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read (data one cycle after address), write on mem_we.
  logic [63:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [63:0] pre_data;
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[10:3]];
    if (pre_we)      mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_addr[10:3]] <= mem_wdata;
  end

  typedef struct {
    logic        is_data;
    logic        chk;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        chk;
    logic [63:0] rdata;
    logic        err;
    logic [63:0] mem_wd;
    int          lat;
  } vec_t;

  exp_t        sb[$];
  logic [63:0] wq[$];
  vec_t        vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic is_data, input logic chk, input logic [63:0] rdata,
                          input logic err);
    exp_t e;
    e.is_data = is_data;
    e.chk     = chk;
    e.rdata   = rdata;
    e.err     = err;
    sb.push_back(e);
  endtask

  function automatic vec_t mk(input logic is_data, input logic we, input logic [1:0] size,
                              input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic chk, input logic [63:0] rdata, input logic err,
                              input logic [63:0] mem_wd, input int lat);
    vec_t v;
    v.is_data = is_data; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.chk = chk; v.rdata = rdata; v.err = err; v.mem_wd = mem_wd;
    v.lat = lat;
    return v;
  endfunction

  // Scoreboard monitor: pop an expectation on every valid pulse and write.
  always @(negedge clk) begin
    exp_t e;
    if (if_valid || d_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: if_valid=%0b d_valid=%0b required none", if_valid, d_valid);
      end else begin
        e = sb.pop_front();
        check("valid_port", {63'b0, d_valid}, {63'b0, e.is_data});
        if (e.is_data) begin
          check("d_err", {63'b0, d_err}, {63'b0, e.err});
          if (e.chk) check("d_rdata", d_rdata, e.rdata);
        end else begin
          check("if_err", {63'b0, if_err}, {63'b0, e.err});
          if (e.chk) check("if_rdata", {32'b0, if_rdata}, e.rdata);
        end
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mem_we: mem_we=1 addr=%h required no write", mem_addr);
      end else begin
        check("mem_wdata", mem_wdata, wq.pop_front());
      end
    end
  end

  task automatic preload(input logic [63:0] a, input logic [63:0] v);
    pre_we   = 1'b1;
    pre_idx  = a[10:3];
    pre_data = v;
    @(posedge clk);
    #1;
    pre_we   = 1'b0;
  endtask

  // Must be entered at a falling edge with the request already driven.
  task automatic finish(input logic is_data, input int exp_lat, input string tag);
    int   n;
    int   lat;
    logic seen;
    n = 0;
    while (!(is_data ? d_gnt : if_gnt) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(is_data ? d_gnt : if_gnt)) begin
      checks++;
      errors++;
      $display("FAIL %s_gnt: no grant within 20 cycles, required a grant", tag);
      if_req = 1'b0;
      d_req  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (is_data) d_req = 1'b0;
    else         if_req = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      seen = is_data ? d_valid : if_valid;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_valid: no valid pulse within 30 cycles, required one", tag);
    end else begin
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    end
  endtask

  task automatic do_req(input vec_t v, input int idx);
    logic [63:0] addr_before;
    addr_before = mem_addr;
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_unsigned = v.uns;
      d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    push_exp(v.is_data, v.chk, v.rdata, v.err);
    if (v.we && !v.err) wq.push_back(v.mem_wd);
    @(negedge clk);
    finish(v.is_data, v.lat, $sformatf("vec%0d", idx));
    if (v.err) check($sformatf("vec%0d_misal_mem_addr", idx), mem_addr, addr_before);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    int n;
    rst_n = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;

    vecs.push_back(mk(0, 0, 2'b10, 0, 64'h100, 0, 1, 64'h13000093, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b00, 0, 64'h203, 0, 1, 64'hFFFFFFFF_FFFFFF80, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b00, 1, 64'h203, 0, 1, 64'h00000000_00000080, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b01, 0, 64'h202, 0, 1, 64'hFFFFFFFF_FFFF80FF, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b10, 0, 64'h200, 0, 1, 64'hFFFFFFFF_80FF0000, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b10, 1, 64'h200, 0, 1, 64'h00000000_80FF0000, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b11, 1, 64'h500, 0, 1, 64'h88776655_44332211, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b01, 0, 64'h506, 0, 1, 64'hFFFFFFFF_FFFF8877, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b10, 0, 64'h504, 0, 1, 64'hFFFFFFFF_88776655, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b00, 0, 64'h501, 0, 1, 64'h00000000_00000022, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b00, 0, 64'h507, 0, 1, 64'hFFFFFFFF_FFFFFF88, 0, 0, 3));
    vecs.push_back(mk(1, 1, 2'b01, 0, 64'h302, 64'hBEEF, 0, 0, 0, 64'h11223344_BEEF7788, 3));
    vecs.push_back(mk(1, 0, 2'b11, 0, 64'h300, 0, 1, 64'h11223344_BEEF7788, 0, 0, 3));
    vecs.push_back(mk(1, 1, 2'b11, 0, 64'h600, 64'hDEADBEEF_CAFEF00D, 0, 0, 0,
                      64'hDEADBEEF_CAFEF00D, 1));
    vecs.push_back(mk(1, 1, 2'b00, 0, 64'h607, 64'h37F, 0, 0, 0, 64'h7FADBEEF_CAFEF00D, 3));
    vecs.push_back(mk(1, 1, 2'b10, 0, 64'h604, 64'hFFFFFFFF_11111111, 0, 0, 0,
                      64'h11111111_CAFEF00D, 3));
    vecs.push_back(mk(1, 0, 2'b11, 0, 64'h600, 0, 1, 64'h11111111_CAFEF00D, 0, 0, 3));
    vecs.push_back(mk(1, 0, 2'b10, 0, 64'h401, 0, 1, 64'h0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 64'h002, 0, 1, 64'h0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 2'b01, 0, 64'h303, 64'h1234, 1, 64'h0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 2'b11, 0, 64'h504, 0, 1, 64'h0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 2'b01, 1, 64'h201, 0, 1, 64'h0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 2'b11, 0, 64'h300, 0, 1, 64'h11223344_BEEF7788, 0, 0, 3));

    repeat (2) @(posedge clk);
    #1;
    preload(64'h100, 64'hAAAAAAAA_13000093);
    preload(64'h200, 64'h00000000_80FF0000);
    preload(64'h300, 64'h11223344_55667788);
    preload(64'h500, 64'h88776655_44332211);
    preload(64'h700, 64'h01234567_89ABCDEF);

    // Reset state, with a fetch already pending.
    if_req  = 1'b1;
    if_addr = 64'h104;
    push_exp(1'b0, 1'b1, 64'hAAAAAAAA, 1'b0);
    @(negedge clk);
    check("rst_if_gnt", {63'b0, if_gnt}, '0);
    check("rst_busy", {63'b0, busy}, '0);
    check("rst_mem_we", {63'b0, mem_we}, '0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_if_rdata", {32'b0, if_rdata}, '0);
    check("rst_d_rdata", d_rdata, '0);
    check("rst_valids", {62'b0, if_valid, d_valid}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("first_idle_if_gnt", {63'b0, if_gnt}, 64'd1);
    finish(1'b0, 3, "rst_fetch");
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) do_req(vecs[i], i);

    // Data beats fetch; fetch waits until the cycle after the return to IDLE.
    if_req = 1'b1; if_addr = 64'h100;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b11; d_unsigned = 1'b0; d_addr = 64'h300;
    push_exp(1'b1, 1'b1, 64'h11223344_BEEF7788, 1'b0);
    push_exp(1'b0, 1'b1, 64'h13000093, 1'b0);
    @(negedge clk);
    check("arb_d_gnt", {63'b0, d_gnt}, 64'd1);
    check("arb_if_gnt_lost", {63'b0, if_gnt}, '0);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_valid && n < 30);
    check("arb_d_lat", 64'(n), 64'd3);
    check("arb_if_gnt_in_resp", {63'b0, if_gnt}, '0);
    @(negedge clk);
    check("arb_if_gnt_idle", {63'b0, if_gnt}, 64'd1);
    finish(1'b0, 3, "arb_fetch");
    @(posedge clk);
    #1;

    // Reset in the middle of a partial store's read phase.
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 64'h700; d_wdata = 64'hFF;
    @(negedge clk);
    check("abort_d_gnt", {63'b0, d_gnt}, 64'd1);
    @(posedge clk);
    #1;
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("abort_busy_read", {63'b0, busy}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("abort_busy", {63'b0, busy}, '0);
    check("abort_mem_we", {63'b0, mem_we}, '0);
    check("abort_d_rdata", d_rdata, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_we || d_valid || busy) bad++;
    end
    check("abort_quiet_cycles", 64'(bad), '0);
    @(posedge clk);
    #1;
    do_req(mk(1, 0, 2'b11, 0, 64'h700, 0, 1, 64'h01234567_89ABCDEF, 0, 0, 3), 99);

    check("sb_drained", 64'(sb.size()), '0);
    check("wq_drained", 64'(wq.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
